// File: rtl/sram_wr_ctrl.sv
// sram_wr_ctrl: valid/ready request bridge to an HM-65162-style 2K x 8 asynchronous SRAM.
// Define SRAM_WR_CTRL_B2B_EN to let consecutive writes chain without releasing CE.
`timescale 1ns/1ps
module sram_wr_ctrl #(
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 3,
  parameter int HOLD_CYC  = 1,
  parameter int RD_CYC    = 5,
  parameter int TURN_CYC  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_ACCESS,
    R_TURN
  } state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] WE_LD    = 4'(WE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RD_LD    = 4'(RD_CYC - 1);
  localparam logic [3:0] TURN_LD  = 4'(TURN_CYC - 1);

  state_t        state;
  state_t        next_state;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          ready_q;
  logic          ready_nxt;
  logic          chain_ok;
  logic          accept;
  logic          capture_rd;
  logic          data_oe;
  logic          data_oe_nxt;
  logic          ce_n_nxt;
  logic          oe_n_nxt;
  logic          we_n_nxt;
  logic [DW-1:0] wdata_q;

  // A chained write is only offered in the final hold cycle so the current write's hold time is never cut short.
`ifdef SRAM_WR_CTRL_B2B_EN
  assign chain_ok = (state == W_HOLD) && (cnt == 4'd0) && req_valid && req_we;
`else
  assign chain_ok = 1'b0;
`endif

  assign req_ready  = ready_q | chain_ok;
  assign accept     = req_valid && req_ready;
  assign capture_rd = (state == R_ACCESS) && (cnt == 4'd0);
  assign busy       = (state != IDLE);
  assign sram_data  = data_oe ? wdata_q : {DW{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      data_oe   <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_nxt;
      ready_q   <= ready_nxt;
      sram_ce_n <= ce_n_nxt;
      sram_oe_n <= oe_n_nxt;
      sram_we_n <= we_n_nxt;
      data_oe   <= data_oe_nxt;
    end
  end

  // Address and write data only move on acceptance, which keeps them stable for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr <= '0;
      wdata_q   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      if (accept) begin
        sram_addr <= req_addr;
        wdata_q   <= req_wdata;
      end
      rd_valid <= capture_rd;
      if (capture_rd) begin
        rd_data <= sram_data;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_we) begin
            next_state = W_SETUP;
            cnt_nxt    = SETUP_LD;
          end else begin
            next_state = R_ACCESS;
            cnt_nxt    = RD_LD;
          end
        end
      end
      W_SETUP: begin
        if (cnt == 4'd0) begin
          next_state = W_PULSE;
          cnt_nxt    = WE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      W_PULSE: begin
        if (cnt == 4'd0) begin
          next_state = W_HOLD;
          cnt_nxt    = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      W_HOLD: begin
        if (cnt == 4'd0) begin
          if (chain_ok) begin
            next_state = W_SETUP;
            cnt_nxt    = SETUP_LD;
          end else begin
            next_state = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      R_ACCESS: begin
        if (cnt == 4'd0) begin
          next_state = R_TURN;
          cnt_nxt    = TURN_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      R_TURN: begin
        if (cnt == 4'd0) begin
          next_state = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_nxt    = 4'd0;
      end
    endcase
  end

  // Strobes are decoded from the upcoming state and registered, so the SRAM pins never glitch.
  always_comb begin
    ce_n_nxt    = 1'b1;
    oe_n_nxt    = 1'b1;
    we_n_nxt    = 1'b1;
    data_oe_nxt = 1'b0;
    ready_nxt   = 1'b0;
    unique case (next_state)
      IDLE: begin
        ready_nxt = 1'b1;
      end
      W_SETUP, W_HOLD: begin
        ce_n_nxt    = 1'b0;
        data_oe_nxt = 1'b1;
      end
      W_PULSE: begin
        ce_n_nxt    = 1'b0;
        we_n_nxt    = 1'b0;
        data_oe_nxt = 1'b1;
      end
      R_ACCESS: begin
        ce_n_nxt = 1'b0;
        oe_n_nxt = 1'b0;
      end
      default: begin
        ready_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_wr_ctrl.sv
// tb_sram_wr_ctrl: scoreboard bench for sram_wr_ctrl driving a behavioural HM-65162 model with timing checks.
`timescale 1ns/1ps
module tb_sram_wr_ctrl;

  localparam int AW        = 11;
  localparam int DW        = 8;
  localparam int SETUP_CYC = 1;
  localparam int WE_CYC    = 3;
  localparam int HOLD_CYC  = 1;
  localparam int RD_CYC    = 5;
  localparam int TURN_CYC  = 2;
  localparam int WR_SPAN   = SETUP_CYC + WE_CYC + HOLD_CYC;
  localparam int WE2_CYC   = 2;
`ifdef SRAM_WR_CTRL_B2B_EN
  localparam int B2B = 1;
`else
  localparam int B2B = 0;
`endif

  // HM-65162 minimum timings in ns
  localparam real T_AS  = 10.0;
  localparam real T_WP  = 55.0;
  localparam real T_DW  = 30.0;
  localparam real T_WR  = 20.0;
  localparam real T_OHZ = 40.0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  wire           req_ready, rd_valid, busy, sram_ce_n, sram_oe_n, sram_we_n;
  wire  [DW-1:0] rd_data;
  wire  [AW-1:0] sram_addr;
  tri0  [DW-1:0] sram_data;

  logic          req_valid2 = 1'b0;
  logic          req_we2 = 1'b0;
  logic [AW-1:0] req_addr2 = '0;
  logic [DW-1:0] req_wdata2 = '0;
  wire           req_ready2, rd_valid2, busy2, sram_ce_n2, sram_oe_n2, sram_we_n2;
  wire  [DW-1:0] rd_data2;
  wire  [AW-1:0] sram_addr2;
  tri0  [DW-1:0] sram_data2;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit checks_on = 1'b0;

  logic [DW-1:0] mem       [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  int            cyc_q [$];

  sram_wr_ctrl #(
    .AW(AW), .DW(DW), .SETUP_CYC(SETUP_CYC), .WE_CYC(WE_CYC), .HOLD_CYC(HOLD_CYC),
    .RD_CYC(RD_CYC), .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_wr_ctrl #(
    .AW(AW), .DW(DW), .SETUP_CYC(SETUP_CYC), .WE_CYC(WE2_CYC), .HOLD_CYC(HOLD_CYC),
    .RD_CYC(RD_CYC), .TURN_CYC(TURN_CYC)
  ) dut_short (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .rd_valid(rd_valid2), .rd_data(rd_data2),
    .busy(busy2), .sram_addr(sram_addr2), .sram_data(sram_data2), .sram_ce_n(sram_ce_n2),
    .sram_oe_n(sram_oe_n2), .sram_we_n(sram_we_n2)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkTiming(input string name, input real actual, input real minimum);
    compared++;
    if (actual < minimum) begin
      mismatched++;
      $display("[TB] FAIL %s: measured %0.1f ns, required >= %0.1f ns (t=%0t)", name, actual, minimum, $time);
    end
  endtask

  // Issue one request, wait (bounded) for acceptance and update the reference model.
  task automatic applyStimulus(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input bit keep, output int acc_cyc);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    #1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("req_accepted", {31'd0, req_ready}, 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep) req_valid = 1'b0;
    if (we) begin
      model_mem[addr] = data;
    end else begin
      exp_q.push_back(model_mem[addr]);
      cyc_q.push_back(acc_cyc + RD_CYC);
    end
  endtask

  // Behavioural SRAM: drives on CE&OE with WE high, commits on the WE rising edge.
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : {DW{1'bz}};

  always @(posedge sram_we_n) begin
    if (!rst && !sram_ce_n) mem[sram_addr] = sram_data;
  end

  realtime t_addr = 0.0, t_data = 0.0, t_we_fall = 0.0, t_we_rise = 0.0, t_oe_rise = -1000.0;
  bit hold_armed = 1'b0;

  always @(sram_addr or sram_data) begin
    if (hold_armed && !rst) begin
      hold_armed = 1'b0;
      checkTiming("t_wr_hold", $realtime - t_we_rise, T_WR);
    end
    t_addr = $realtime;
    t_data = $realtime;
  end

  always @(negedge sram_we_n) begin
    t_we_fall = $realtime;
    if (checks_on && !rst) checkTiming("t_as_addr_setup", t_we_fall - t_addr, T_AS);
  end

  always @(posedge sram_we_n) begin
    if (checks_on && !rst) begin
      checkTiming("t_wp_pulse", $realtime - t_we_fall, T_WP);
      checkTiming("t_dw_data_setup", $realtime - t_data, T_DW);
      t_we_rise  = $realtime;
      hold_armed = 1'b1;
    end
  end

  always @(posedge sram_oe_n) t_oe_rise = $realtime;

  always @(negedge sram_ce_n) begin
    if (checks_on && !rst && sram_oe_n) checkTiming("t_ohz_turnaround", $realtime - t_oe_rise, T_OHZ);
  end

  // Short-pulse detector on the WE_CYC=2 instance.
  realtime t2_fall = 0.0;
  real     width2 = 0.0;
  bit      seen2 = 1'b0;
  bit      short2 = 1'b0;

  always @(negedge sram_we_n2) t2_fall = $realtime;

  always @(posedge sram_we_n2) begin
    if (checks_on && !rst) begin
      width2 = $realtime - t2_fall;
      seen2  = 1'b1;
      short2 = (width2 < T_WP);
      if (short2) $display("[TB] SRAM model (WE_CYC=%0d): write pulse too short, %0.1f ns", WE2_CYC, width2);
    end
  end

  // Scoreboard monitor plus bus-ownership and address-stability checks.
  logic          prev_ce_n = 1'b1, prev_we_n = 1'b1, prev_oe_n = 1'b1;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    int c;
    if (checks_on && !rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          checkOutput("rd_data", {24'd0, rd_data}, {24'd0, e});
          checkOutput("rd_latency_cycle", cyc, c);
        end
      end
      if (sram_ce_n) checkOutput("bus_released", {24'd0, sram_data}, 32'd0);
      if (!sram_oe_n) checkOutput("read_bus_no_contention", {24'd0, sram_data}, {24'd0, model_mem[sram_addr]});
      if (!sram_ce_n && !prev_ce_n) begin
        if (!(B2B == 1 && sram_we_n && prev_we_n && sram_oe_n && prev_oe_n))
          checkOutput("addr_stable_ce_low", {21'd0, sram_addr}, {21'd0, prev_addr});
      end
    end
    prev_ce_n = sram_ce_n;
    prev_we_n = sram_we_n;
    prev_oe_n = sram_oe_n;
    prev_addr = sram_addr;
  end

  initial begin : watchdog
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int acc, prev_acc, n, ce_low, we_low, oe_low, data_hits, we_first;
    logic [DW-1:0] saved;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]       = i[DW-1:0];
      model_mem[i] = i[DW-1:0];
    end

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    checkOutput("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    checkOutput("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("rst_bus", {24'd0, sram_data}, 32'd0);
    checkOutput("rst_addr", {21'd0, sram_addr}, 32'd0);
    checkOutput("rst_rd_data", {24'd0, rd_data}, 32'd0);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    checks_on = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("post_rst_ce_n", {31'd0, sram_ce_n}, 32'd1);

    $display("[TB] single write 0x012 <= 0xA5");
    applyStimulus(1'b1, 11'h012, 8'hA5, 1'b0, acc);
    ce_low = 0; we_low = 0; oe_low = 0; data_hits = 0; we_first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!sram_ce_n) ce_low++;
      if (!sram_we_n) begin
        we_low++;
        if (we_first == 0) we_first = i;
      end
      if (!sram_oe_n) oe_low++;
      if (!sram_ce_n && sram_data == 8'hA5) data_hits++;
    end
    checkOutput("wr_ce_low_cycles", ce_low, WR_SPAN);
    checkOutput("wr_we_low_cycles", we_low, WE_CYC);
    checkOutput("wr_we_first_cycle", we_first, SETUP_CYC + 1);
    checkOutput("wr_oe_low_cycles", oe_low, 0);
    checkOutput("wr_data_on_bus_cycles", data_hits, WR_SPAN);

    $display("[TB] readback 0x012 and read 0x01F");
    applyStimulus(1'b0, 11'h012, 8'h00, 1'b0, acc);
    applyStimulus(1'b0, 11'h01F, 8'h00, 1'b0, acc);
    n = 0; oe_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (!sram_oe_n) oe_low++;
    end
    checkOutput("rd_ready_low_cycles", n, RD_CYC + TURN_CYC);
    checkOutput("rd_oe_low_cycles", oe_low, RD_CYC);

    $display("[TB] back-to-back writes 0x000..0x003");
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, AW'(i), DW'(8'h10 + i), (i < 3), acc);
      if (i > 0) checkOutput("b2b_spacing", acc - prev_acc, WR_SPAN + (B2B == 1 ? 0 : 1));
      prev_acc = acc;
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, AW'(i), 8'h00, 1'b0, acc);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 150; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom), 1'b0, acc);
    end

    $display("[TB] reset during write pulse");
    n = 0;
    while (n < 50 && (busy || exp_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    saved = model_mem[11'h030];
    applyStimulus(1'b1, 11'h030, 8'h5A, 1'b0, acc);
    model_mem[11'h030] = saved;
    n = 0;
    while (n < 10 && sram_we_n) begin
      @(negedge clk);
      n++;
    end
    checkOutput("we_pulse_reached", {31'd0, sram_we_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    checkOutput("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
    checkOutput("abort_bus", {24'd0, sram_data}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready_after", {31'd0, req_ready}, 32'd1);
    applyStimulus(1'b0, 11'h030, 8'h00, 1'b0, acc);

    $display("[TB] WE_CYC=%0d instance write", WE2_CYC);
    @(negedge clk);
    req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = 11'h005; req_wdata2 = 8'h3C;
    #1;
    n = 0;
    while (!req_ready2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    n = 0;
    while (!seen2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("we_cyc2_short_pulse_flagged", {31'd0, short2}, 32'd1);

    n = 0;
    while (n < 50 && (busy || exp_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 64; i++) checkOutput("sram_contents", {24'd0, mem[i]}, {24'd0, model_mem[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
